// File: rtl/drive_pkg.sv
// Shared definitions for the figure-8 drive FSM and the OI command sequencer:
// state codes, Open Interface opcodes and per-code packet lengths.
package drive_pkg;

  // State codes produced by the drive FSM
  localparam logic [2:0] ST_STOP       = 3'd0;
  localparam logic [2:0] ST_CLKWISE    = 3'd1;
  localparam logic [2:0] ST_CNTCLKWISE = 3'd2;
  localparam logic [2:0] ST_INIT       = 3'd3;
  localparam logic [2:0] ST_SONGINIT   = 3'd4;

  // Open Interface opcodes
  localparam logic [7:0] OP_START = 8'd128;
  localparam logic [7:0] OP_FULL  = 8'd132;
  localparam logic [7:0] OP_SONG  = 8'd140;
  localparam logic [7:0] OP_PLAY  = 8'd141;
  localparam logic [7:0] OP_DRIVE = 8'd137;

  // Packet lengths in bytes
  localparam int LEN_INIT     = 2;
  localparam int LEN_SONGINIT = 7;
  localparam int LEN_DRIVE    = 5;

  // Sequencer control states
  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_SEND = 1'b1
  } seq_state_e;

  // Codes 5..7 are not real drive states and never produce a packet
  function automatic logic code_valid(input logic [2:0] code);
    return (code <= ST_SONGINIT);
  endfunction

  // Index of the final byte of the packet for a given code
  function automatic logic [2:0] pkt_last_idx(input logic [2:0] code);
    case (code)
      ST_INIT:     return 3'(LEN_INIT - 1);
      ST_SONGINIT: return 3'(LEN_SONGINIT - 1);
      default:     return 3'(LEN_DRIVE - 1);
    endcase
  endfunction

endpackage

// File: rtl/oi_cmd_sequencer_if.sv
// Byte stream from the sequencer to the UART transmitter (valid/ready).
interface oi_cmd_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/oi_seq_rom.sv
// Combinational packet table: maps (state code, byte index) to the OI byte
// and flags the final byte of that packet.
module oi_seq_rom
  import drive_pkg::*;
#(
  parameter int VELOCITY  = 200,
  parameter int RADIUS    = 500,
  parameter int SONG_NOTE = 72,
  parameter int SONG_DUR  = 32
) (
  input  logic [2:0] code,
  input  logic [2:0] idx,
  output logic [7:0] data,
  output logic       last
);

  localparam logic [15:0] VEL16   = 16'(VELOCITY);
  localparam logic [15:0] RAD_CW  = 16'(-RADIUS);
  localparam logic [15:0] RAD_CCW = 16'(RADIUS);
  localparam logic [7:0]  NOTE8   = 8'(SONG_NOTE);
  localparam logic [7:0]  DUR8    = 8'(SONG_DUR);

  logic [15:0] radius;

  // Byte lookup; drive packets share one layout with a per-code radius
  always_comb begin
    data   = 8'd0;
    radius = (code == ST_CLKWISE) ? RAD_CW : RAD_CCW;
    case (code)
      ST_INIT: begin
        case (idx)
          3'd0:    data = OP_START;
          3'd1:    data = OP_FULL;
          default: data = 8'd0;
        endcase
      end
      ST_SONGINIT: begin
        case (idx)
          3'd0:    data = OP_SONG;
          3'd1:    data = 8'd0;
          3'd2:    data = 8'd1;
          3'd3:    data = NOTE8;
          3'd4:    data = DUR8;
          3'd5:    data = OP_PLAY;
          default: data = 8'd0;
        endcase
      end
      ST_CLKWISE, ST_CNTCLKWISE: begin
        case (idx)
          3'd0:    data = OP_DRIVE;
          3'd1:    data = VEL16[15:8];
          3'd2:    data = VEL16[7:0];
          3'd3:    data = radius[15:8];
          3'd4:    data = radius[7:0];
          default: data = 8'd0;
        endcase
      end
      default: begin
        // STOP: drive with zero velocity and zero radius
        data = (idx == 3'd0) ? OP_DRIVE : 8'd0;
      end
    endcase
    last = (idx == pkt_last_idx(code));
  end

endmodule

// File: rtl/oi_cmd_sequencer.sv
// Watches the drive FSM state code and streams the matching OI command
// packet to the UART. Packets are never cut short; changes seen while a
// packet is in flight collapse to whatever state is current afterwards.
module oi_cmd_sequencer
  import drive_pkg::*;
#(
  parameter int VELOCITY  = 200,
  parameter int RADIUS    = 500,
  parameter int SONG_NOTE = 72,
  parameter int SONG_DUR  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 state,
  oi_cmd_sequencer_if.master         tx,
  output logic                       busy,
  output logic                       seq_done,
  output logic [2:0]                 cur_seq
);

  seq_state_e fsm_reg;
  logic [2:0] idx_reg;
  logic [2:0] last_sent_reg;
  logic       last_reg;

  logic [2:0] rom_code;
  logic [2:0] rom_idx;
  logic [7:0] rom_data;
  logic       rom_last;
  logic       start;

  // Table address: byte 0 of the incoming code in IDLE, else the next byte
  always_comb begin
    rom_code = cur_seq;
    rom_idx  = idx_reg + 3'd1;
    if (fsm_reg == SEQ_IDLE) begin
      rom_code = state;
      rom_idx  = 3'd0;
    end
  end

  assign start = (fsm_reg == SEQ_IDLE) && (state != last_sent_reg) && code_valid(state);

  oi_seq_rom #(
    .VELOCITY  (VELOCITY),
    .RADIUS    (RADIUS),
    .SONG_NOTE (SONG_NOTE),
    .SONG_DUR  (SONG_DUR)
  ) u_rom (
    .code (rom_code),
    .idx  (rom_idx),
    .data (rom_data),
    .last (rom_last)
  );

  // Control FSM, byte index and registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg       <= SEQ_IDLE;
      idx_reg       <= 3'd0;
      last_sent_reg <= ST_STOP;
      last_reg      <= 1'b0;
      tx.tx_valid   <= 1'b0;
      tx.tx_data    <= 8'd0;
      busy          <= 1'b0;
      seq_done      <= 1'b0;
      cur_seq       <= ST_STOP;
    end else begin
      seq_done <= 1'b0;
      case (fsm_reg)
        SEQ_IDLE: begin
          if (start) begin
            cur_seq     <= state;
            idx_reg     <= 3'd0;
            last_reg    <= rom_last;
            tx.tx_data  <= rom_data;
            tx.tx_valid <= 1'b1;
            busy        <= 1'b1;
            fsm_reg     <= SEQ_SEND;
          end
        end
        SEQ_SEND: begin
          if (tx.tx_valid && tx.tx_ready) begin
            if (last_reg) begin
              tx.tx_valid   <= 1'b0;
              tx.tx_data    <= 8'd0;
              busy          <= 1'b0;
              seq_done      <= 1'b1;
              last_sent_reg <= cur_seq;
              fsm_reg       <= SEQ_IDLE;
            end else begin
              idx_reg    <= idx_reg + 3'd1;
              tx.tx_data <= rom_data;
              last_reg   <= rom_last;
            end
          end
        end
        default: fsm_reg <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oi_cmd_sequencer.sv
// Self-checking bench for oi_cmd_sequencer: directed scenarios followed by
// random state changes, all checked against a packet-level reference model.
module tb_oi_cmd_sequencer;

  localparam int VELOCITY  = 200;
  localparam int RADIUS    = 500;
  localparam int SONG_NOTE = 72;
  localparam int SONG_DUR  = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state;
  logic       busy;
  logic       seq_done;
  logic [2:0] cur_seq;

  oi_cmd_sequencer_if tif ();

  oi_cmd_sequencer #(
    .VELOCITY  (VELOCITY),
    .RADIUS    (RADIUS),
    .SONG_NOTE (SONG_NOTE),
    .SONG_DUR  (SONG_DUR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .tx       (tif),
    .busy     (busy),
    .seq_done (seq_done),
    .cur_seq  (cur_seq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_b[7];
  int exp_len;
  int model_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference packet contents straight from the OI command layout
  task automatic build_pkt(input int code);
    int r;
    for (int k = 0; k < 7; k++) exp_b[k] = 0;
    case (code)
      3: begin exp_len = 2; exp_b[0] = 128; exp_b[1] = 132; end
      4: begin
        exp_len = 7;
        exp_b[0] = 140; exp_b[1] = 0; exp_b[2] = 1; exp_b[3] = SONG_NOTE;
        exp_b[4] = SONG_DUR; exp_b[5] = 141; exp_b[6] = 0;
      end
      0: begin exp_len = 5; exp_b[0] = 137; end
      default: begin
        exp_len = 5;
        r = (code == 1) ? (65536 - RADIUS) % 65536 : RADIUS;
        exp_b[0] = 137;
        exp_b[1] = VELOCITY / 256;
        exp_b[2] = VELOCITY % 256;
        exp_b[3] = r / 256;
        exp_b[4] = r % 256;
      end
    endcase
  endtask

  // Expect a packet for 'code' one cycle after the current negedge.
  // mid0/mid1 (>=0) change the state while byte 0/1 is on the bus.
  // abort_after>0 returns right after that many bytes have been accepted.
  task automatic run_packet(input int code, input int pct, input int mid0,
                            input int mid1, input int abort_after);
    build_pkt(code);
    @(negedge clk);
    chk("latency_valid", {31'd0, tif.tx_valid}, 1);
    chk("busy_start", {31'd0, busy}, 1);
    chk("seq_done_low", {31'd0, seq_done}, 0);
    chk("cur_seq_busy", {29'd0, cur_seq}, code);
    for (int i = 0; i < exp_len; i++) begin
      int stalls = 0;
      bit go = 1'b0;
      while (!go) begin
        chk($sformatf("pkt%0d_byte%0d", code, i), {24'd0, tif.tx_data}, exp_b[i]);
        chk("valid_hold", {31'd0, tif.tx_valid}, 1);
        if (stalls == 0 && i == 0 && mid0 >= 0) state = 3'(mid0);
        if (stalls == 0 && i == 1 && mid1 >= 0) state = 3'(mid1);
        go = ($urandom_range(0, 99) < pct) || (stalls >= 50);
        tif.tx_ready = go;
        stalls++;
        @(negedge clk);
      end
      $display("byte code=%0d idx=%0d data=%02h stalls=%0d", code, i, exp_b[i], stalls - 1);
      if (abort_after > 0 && i + 1 == abort_after) return;
    end
    chk("seq_done_pulse", {31'd0, seq_done}, 1);
    chk("valid_drop", {31'd0, tif.tx_valid}, 0);
    chk("busy_end", {31'd0, busy}, 0);
    chk("cur_seq_done", {29'd0, cur_seq}, code);
    model_last = code;
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_valid"}, {31'd0, tif.tx_valid}, 0);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
    end
  endtask

  // After a packet, keep sending whatever the current state now calls for
  task automatic drain_followups();
    while (int'(state) <= 4 && int'(state) != model_last)
      run_packet(int'(state), 100, -1, -1, 0);
  endtask

  initial begin
    rst = 1'b1;
    state = 3'd0;
    tif.tx_ready = 1'b0;
    model_last = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, tif.tx_valid}, 0);
    chk("rst_data", {24'd0, tif.tx_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_seq_done", {31'd0, seq_done}, 0);
    chk("rst_cur_seq", {29'd0, cur_seq}, 0);
    rst = 1'b0;
    tif.tx_ready = 1'b1;
    idle_check("stop_idle", 20);

    // INIT at full rate
    state = 3'd3;
    run_packet(3, 100, -1, -1, 0);
    idle_check("after_init", 2);

    // CLKWISE then CNTCLKWISE with default parameters
    state = 3'd1;
    run_packet(1, 100, -1, -1, 0);
    state = 3'd2;
    run_packet(2, 100, -1, -1, 0);

    // SONGINIT with a sparse ready
    state = 3'd4;
    run_packet(4, 30, -1, -1, 0);

    // 3 -> 4 -> 1 while INIT is in flight: only CLKWISE follows
    state = 3'd3;
    run_packet(3, 100, 4, 1, 0);
    run_packet(1, 100, -1, -1, 0);
    idle_check("after_coalesce", 3);

    // Leave and return to last_sent during a packet: nothing extra sent
    state = 3'd2;
    run_packet(2, 100, 3, 2, 0);
    idle_check("returned", 5);

    // Invalid codes never start a packet
    state = 3'd6;
    idle_check("code6", 5);
    state = 3'd7;
    idle_check("code7", 5);
    state = 3'd0;
    run_packet(0, 100, -1, -1, 0);

    // Reset after the second SONGINIT byte, then a clean restart
    state = 3'd4;
    run_packet(4, 100, -1, -1, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", {31'd0, tif.tx_valid}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_cur_seq", {29'd0, cur_seq}, 0);
    chk("abort_data", {24'd0, tif.tx_data}, 0);
    rst = 1'b0;
    model_last = 0;
    run_packet(4, 100, -1, -1, 0);

    // Random state changes, random ready density, random mid-packet changes
    for (int it = 0; it < 40; it++) begin
      int nc = $urandom_range(0, 7);
      int pct = $urandom_range(20, 100);
      int m0 = $urandom_range(0, 7);
      state = 3'(nc);
      if (nc <= 4 && nc != model_last) begin
        run_packet(nc, pct, m0, -1, 0);
        drain_followups();
      end else begin
        idle_check("rand_idle", 3);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
